// File: rtl/vga_ctrl_pkg.sv
// rtl/vga_ctrl_pkg.sv - shared types and defaults for the VGA pattern step scheduler
package vga_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int PKG_DEFAULT_DIV  = 30;
    localparam int PKG_PULSE_CYCLES = 2;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector
module rise_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    // previous-cycle copy of the input level
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/pattern_step_scheduler.sv
// rtl/pattern_step_scheduler.sv - frame-rate step pulse and reset strobe sequencer for the pattern counter
module pattern_step_scheduler
    import vga_ctrl_pkg::*;
#(
    parameter int DIV_W        = 6,
    parameter int DEFAULT_DIV  = PKG_DEFAULT_DIV,
    parameter int PULSE_CYCLES = PKG_PULSE_CYCLES,
    parameter int CNT_W        = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_vsync,
    input  logic             i_run,
    input  logic             i_div_load,
    input  logic [DIV_W-1:0] i_div_value,
    input  logic             i_clear,
    input  logic             i_step_req,
    output logic             o_step_ack,
    output logic             o_step_drop,
    output logic             o_step_en,
    output logic             o_cnt_reset,
    output logic [CNT_W-1:0] o_step_count,
    output logic             o_busy
);

    localparam int             PH_W    = $clog2(PULSE_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PULSE_CYCLES - 1);

    state_t             r_state, w_state_nxt;
    logic [PH_W-1:0]    r_phase, w_phase_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic [DIV_W-1:0]   r_frame_cnt, w_frame_nxt;
    logic [CNT_W-1:0]   r_step_count, w_count_nxt;
    logic               r_pending, w_pending_nxt;
    logic               r_single, w_single_nxt;
    logic               r_step_en, r_cnt_reset, r_ack, r_drop, r_busy;
    logic               w_ack_nxt, w_drop_nxt, w_cnt_reset_nxt;
    logic               w_tick, w_terminal, w_req_any, w_phase_last;
    logic               w_start, w_start_single;

    rise_detect u_vsync_rise (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sig   (i_vsync),
        .o_rise  (w_tick)
    );

    assign w_req_any    = i_step_req | r_pending;
    assign w_phase_last = (r_phase == PH_LAST);
    assign w_terminal   = (r_state == ST_WAIT) && i_run && w_tick &&
                          (r_frame_cnt == r_div - 1'b1);

    // next-state, frame counting, request pending and strobe decisions
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_frame_nxt     = r_frame_cnt;
        w_div_nxt       = r_div;
        w_count_nxt     = r_step_count;
        w_pending_nxt   = r_pending;
        w_single_nxt    = r_single;
        w_ack_nxt       = 1'b0;
        w_drop_nxt      = 1'b0;
        w_cnt_reset_nxt = 1'b0;
        w_start         = 1'b0;
        w_start_single  = 1'b0;

        // requests arriving mid-pulse/gap are held one deep; the last gap cycle serves directly
        if ((r_state == ST_PULSE) || ((r_state == ST_GAP) && !w_phase_last)) begin
            if (i_step_req) begin
                if (r_pending) w_drop_nxt    = 1'b1;
                else           w_pending_nxt = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_start        = 1'b1;
                    w_start_single = 1'b1;
                end else if (i_run) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_run && w_tick) begin
                    w_frame_nxt = w_terminal ? '0 : r_frame_cnt + 1'b1;
                end
                if (w_req_any || w_terminal) begin
                    w_start        = 1'b1;
                    w_start_single = w_req_any;
                end else if (!i_run) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (w_phase_last) begin
                    w_state_nxt = ST_GAP;
                    w_phase_nxt = '0;
                    w_ack_nxt   = r_single;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            ST_GAP: begin
                if (!w_phase_last) begin
                    w_phase_nxt = r_phase + 1'b1;
                end else if (w_req_any) begin
                    w_drop_nxt     = i_step_req & r_pending;
                    w_start        = 1'b1;
                    w_start_single = 1'b1;
                end else begin
                    w_state_nxt = i_run ? ST_WAIT : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_start) begin
            w_state_nxt   = ST_PULSE;
            w_phase_nxt   = '0;
            w_count_nxt   = r_step_count + 1'b1;
            w_single_nxt  = w_start_single;
            w_pending_nxt = 1'b0;
        end

        if (i_div_load) begin
            w_div_nxt   = (i_div_value == '0) ? DIV_W'(1) : i_div_value;
            w_frame_nxt = '0;
        end

        // clear wins over everything and parks the FSM in a full low gap
        if (i_clear) begin
            w_state_nxt     = ST_GAP;
            w_phase_nxt     = '0;
            w_frame_nxt     = '0;
            w_count_nxt     = '0;
            w_pending_nxt   = 1'b0;
            w_single_nxt    = 1'b0;
            w_ack_nxt       = 1'b0;
            w_drop_nxt      = i_step_req;
            w_cnt_reset_nxt = 1'b1;
        end
    end

    // state and registered outputs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_phase      <= '0;
            r_div        <= DIV_W'(DEFAULT_DIV);
            r_frame_cnt  <= '0;
            r_step_count <= '0;
            r_pending    <= 1'b0;
            r_single     <= 1'b0;
            r_step_en    <= 1'b0;
            r_cnt_reset  <= 1'b0;
            r_ack        <= 1'b0;
            r_drop       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_div        <= w_div_nxt;
            r_frame_cnt  <= w_frame_nxt;
            r_step_count <= w_count_nxt;
            r_pending    <= w_pending_nxt;
            r_single     <= w_single_nxt;
            r_step_en    <= (w_state_nxt == ST_PULSE);
            r_cnt_reset  <= w_cnt_reset_nxt;
            r_ack        <= w_ack_nxt;
            r_drop       <= w_drop_nxt;
            r_busy       <= (w_state_nxt == ST_PULSE) || (w_state_nxt == ST_GAP);
        end
    end

    assign o_step_en    = r_step_en;
    assign o_cnt_reset  = r_cnt_reset;
    assign o_step_ack   = r_ack;
    assign o_step_drop  = r_drop;
    assign o_step_count = r_step_count;
    assign o_busy       = r_busy;

endmodule
